// File: rtl/multi_strand_select_stage_pkg.sv
// Shared definitions for the multi-strand select stage: vector-memory-transfer
// opcode fields, NOP encoding and the select FSM state encoding.
package multi_strand_select_stage_pkg;

    localparam logic [1:0]  VMT_CLASS  = 2'b10;
    localparam logic [3:0]  VMT_MIN_OP = 4'b0110;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_VMT  = 1'b1
    } state_e;

    // A vector memory transfer occupies one issue slot per lane.
    function automatic logic is_vmt(input logic [31:0] instr);
        return (instr[31:30] == VMT_CLASS) && (instr[28:25] >= VMT_MIN_OP);
    endfunction

endpackage

// File: rtl/multi_strand_select_stage_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_o
);

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned      offs);
        int unsigned sum;
        sum = {{(32-IDX_W){1'b0}}, base} + offs;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return IDX_W'(sum);
    endfunction

    // Scan requesters starting at the pointer; first hit wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_o && req_i[wrap_add(ptr_i, i)]) begin
                any_o                          = 1'b1;
                grant_o[wrap_add(ptr_i, i)]    = 1'b1;
                grant_idx_o                    = wrap_add(ptr_i, i);
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/multi_strand_select_stage.sv
// Issue-select stage: round-robin over hardware strands, with vector memory
// transfers locking the selected strand for one issue slot per lane.
module multi_strand_select_stage
    import multi_strand_select_stage_pkg::*;
#(
    parameter int NUM_STRANDS = 4,
    parameter int NUM_LANES   = 16,
    parameter int LANE_W      = $clog2(NUM_LANES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [32*NUM_STRANDS-1:0]     instruction_i,
    input  logic [32*NUM_STRANDS-1:0]     pc_i,
    input  logic [NUM_STRANDS-1:0]        strand_valid_i,
    input  logic [NUM_STRANDS-1:0]        flush_i,
    input  logic                          stall_i,
    output logic [NUM_STRANDS-1:0]        strand_ready_o,
    output logic [31:0]                   instruction_o,
    output logic [31:0]                   pc_o,
    output logic [$clog2(NUM_STRANDS)-1:0] strand_id_o,
    output logic [LANE_W-1:0]             lane_select_o,
    output logic                          valid_o
);

    localparam int SW = $clog2(NUM_STRANDS);

    state_e              state_q, state_d;
    logic [SW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]       lock_q, lock_d;
    logic [LANE_W-1:0]   lane_cnt_q, lane_cnt_d;
    logic                valid_q, valid_d;
    logic [31:0]         instr_q, instr_d;
    logic [31:0]         pc_q, pc_d;
    logic [SW-1:0]       sid_q, sid_d;
    logic [LANE_W-1:0]   lane_sel_q, lane_sel_d;
    logic [NUM_STRANDS-1:0] ready_s;

    logic [NUM_STRANDS-1:0] grant_oh_s;
    logic [SW-1:0]          grant_idx_s;
    logic                   any_s;
    logic [31:0]            gr_instr_s, gr_pc_s, lk_instr_s, lk_pc_s;

    function automatic logic [SW-1:0] next_ptr(input logic [SW-1:0] idx);
        return (idx == SW'(NUM_STRANDS - 1)) ? '0 : idx + SW'(1);
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_STRANDS),
        .IDX_W   (SW)
    ) u_arb (
        .req_i       (strand_valid_i & ~flush_i),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant_oh_s),
        .grant_idx_o (grant_idx_s),
        .any_o       (any_s)
    );

    assign gr_instr_s = instruction_i[{grant_idx_s, 5'd0} +: 32];
    assign gr_pc_s    = pc_i[{grant_idx_s, 5'd0} +: 32];
    assign lk_instr_s = instruction_i[{lock_q, 5'd0} +: 32];
    assign lk_pc_s    = pc_i[{lock_q, 5'd0} +: 32];

    assign strand_ready_o = reset ? '0 : ready_s;

    // Next-state, issue selection and pop generation.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lane_cnt_d = lane_cnt_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        sid_d      = sid_q;
        lane_sel_d = lane_sel_q;
        ready_s    = '0;
        if (stall_i) begin
            // A flush still kills the held instruction while stalled.
            if (valid_q && flush_i[sid_q]) begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end else begin
                valid_d = valid_q;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_s) begin
                        valid_d    = 1'b1;
                        instr_d    = gr_instr_s;
                        pc_d       = gr_pc_s;
                        sid_d      = grant_idx_s;
                        lane_sel_d = '0;
                        if (is_vmt(gr_instr_s)) begin
                            state_d    = ST_VMT;
                            lock_d     = grant_idx_s;
                            lane_cnt_d = LANE_W'(1);
                        end else begin
                            ready_s  = grant_oh_s;
                            rr_ptr_d = next_ptr(grant_idx_s);
                        end
                    end else begin
                        valid_d    = 1'b0;
                        instr_d    = NOP_INSTR;
                        pc_d       = 32'h0000_0000;
                        lane_sel_d = '0;
                    end
                end
                ST_VMT: begin
                    if (flush_i[lock_q]) begin
                        state_d    = ST_IDLE;
                        lane_cnt_d = '0;
                        valid_d    = 1'b0;
                        instr_d    = NOP_INSTR;
                    end else begin
                        valid_d    = 1'b1;
                        instr_d    = lk_instr_s;
                        pc_d       = lk_pc_s;
                        sid_d      = lock_q;
                        lane_sel_d = lane_cnt_q;
                        if (lane_cnt_q == LANE_W'(NUM_LANES - 1)) begin
                            ready_s[lock_q] = 1'b1;
                            state_d         = ST_IDLE;
                            rr_ptr_d        = next_ptr(lock_q);
                            lane_cnt_d      = '0;
                        end else begin
                            lane_cnt_d = lane_cnt_q + LANE_W'(1);
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    lane_cnt_d = '0;
                    valid_d    = 1'b0;
                    instr_d    = NOP_INSTR;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            lock_q     <= '0;
            lane_cnt_q <= '0;
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_q       <= 32'h0000_0000;
            sid_q      <= '0;
            lane_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lane_cnt_q <= lane_cnt_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            sid_q      <= sid_d;
            lane_sel_q <= lane_sel_d;
        end
    end

    assign valid_o       = valid_q;
    assign instruction_o = instr_q;
    assign pc_o          = pc_q;
    assign strand_id_o   = sid_q;
    assign lane_select_o = lane_sel_q;

endmodule

// File: tb/tb_multi_strand_select_stage.sv
// Directed bench for the multi-strand select stage (4 strands, 16 lanes).
module tb_multi_strand_select_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] instruction_i;
    logic [127:0] pc_i;
    logic [3:0]   strand_valid_i;
    logic [3:0]   flush_i;
    logic         stall_i;
    logic [3:0]   strand_ready_o;
    logic [31:0]  instruction_o;
    logic [31:0]  pc_o;
    logic [1:0]   strand_id_o;
    logic [3:0]   lane_select_o;
    logic         valid_o;

    logic [31:0] ins_a [4];
    logic [31:0] pc_a  [4];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int s = 0; s < 4; s++) begin
            instruction_i[32*s +: 32] = ins_a[s];
            pc_i[32*s +: 32]          = pc_a[s];
        end
    end

    multi_strand_select_stage #(
        .NUM_STRANDS (4),
        .NUM_LANES   (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .instruction_i  (instruction_i),
        .pc_i           (pc_i),
        .strand_valid_i (strand_valid_i),
        .flush_i        (flush_i),
        .stall_i        (stall_i),
        .strand_ready_o (strand_ready_o),
        .instruction_o  (instruction_o),
        .pc_o           (pc_o),
        .strand_id_o    (strand_id_o),
        .lane_select_o  (lane_select_o),
        .valid_o        (valid_o)
    );

    function automatic logic [31:0] nvi(input int s);
        return 32'h0100_0000 | 32'(s);
    endfunction

    function automatic logic [31:0] vmt(input int s);
        return 32'h8C00_0000 | 32'(s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                           input logic [31:0] pc, input int sid, input int lane);
        chk({tag, ".valid"}, 32'(valid_o), 32'(v));
        chk({tag, ".instr"}, instruction_o, ins);
        chk({tag, ".pc"},    pc_o, pc);
        chk({tag, ".sid"},   32'(strand_id_o), 32'(sid));
        chk({tag, ".lane"},  32'(lane_select_o), 32'(lane));
    endtask

    // Check pop before the edge, then the registered issue after it.
    task automatic issue(input string tag, input logic [3:0] exp_ready, input logic [31:0] ins,
                         input int sid, input int lane);
        #1;
        chk({tag, ".ready"}, 32'(strand_ready_o), 32'(exp_ready));
        tick();
        chk_out(tag, 1'b1, ins, pc_a[sid], sid, lane);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        for (int s = 0; s < 4; s++) begin
            ins_a[s] = nvi(s);
            pc_a[s]  = 32'h0000_1000 + 32'(16 * s);
        end
        reset          = 1'b1;
        stall_i        = 1'b0;
        flush_i        = 4'b0000;
        strand_valid_i = 4'b1111;

        // Reset: pop suppressed, outputs cleared.
        #1;
        chk("rst.ready", 32'(strand_ready_o), 32'h0);
        tick();
        chk_out("rst", 1'b0, 32'h0, 32'h0, 0, 0);
        tick();
        chk("rst2.ready", 32'(strand_ready_o), 32'h0);

        // No strand valid: idle bubbles.
        reset          = 1'b0;
        strand_valid_i = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("idle.ready", 32'(strand_ready_o), 32'h0);
            tick();
            chk("idle.valid", 32'(valid_o), 32'h0);
            chk("idle.instr", instruction_o, 32'h0);
        end

        // Round robin over non-VMT strands: 0,1,2,3,0.
        strand_valid_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            issue("rr", 4'(1 << (k % 4)), nvi(k % 4), k % 4, 0);
        end

        // Opcode field 0101 is below the VMT threshold: single issue.
        ins_a[1]       = 32'h8A00_0001;
        strand_valid_i = 4'b0010;
        issue("op5", 4'b0010, 32'h8A00_0001, 1, 0);

        // Pointer wraps from 2 past 3 to strand 0.
        strand_valid_i = 4'b0001;
        issue("wrap", 4'b0001, nvi(0), 0, 0);

        // Full VMT on strand 1, then strand 2 next.
        ins_a[1]       = vmt(1);
        strand_valid_i = 4'b1111;
        for (int l = 0; l < 16; l++) begin
            issue("vmt1", (l == 15) ? 4'b0010 : 4'b0000, vmt(1), 1, l);
        end
        issue("after_vmt1", 4'b0100, nvi(2), 2, 0);

        // VMT on strand 2 with a 3-cycle stall at lane 5.
        ins_a[1]       = nvi(1);
        ins_a[2]       = vmt(2);
        strand_valid_i = 4'b0100;
        for (int l = 0; l < 6; l++) begin
            issue("vmt2a", 4'b0000, vmt(2), 2, l);
        end
        stall_i        = 1'b1;
        strand_valid_i = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall.ready", 32'(strand_ready_o), 32'h0);
            tick();
            chk_out("stall", 1'b1, vmt(2), pc_a[2], 2, 5);
        end
        stall_i        = 1'b0;
        strand_valid_i = 4'b0100;
        for (int l = 6; l < 16; l++) begin
            issue("vmt2b", (l == 15) ? 4'b0100 : 4'b0000, vmt(2), 2, l);
        end

        // Flush of the issued strand while stalled still clears the output.
        ins_a[2]       = nvi(2);
        strand_valid_i = 4'b1000;
        issue("pre_sf", 4'b1000, nvi(3), 3, 0);
        stall_i = 1'b1;
        flush_i = 4'b1000;
        #1;
        chk("sf.ready", 32'(strand_ready_o), 32'h0);
        tick();
        chk_out("sf", 1'b0, 32'h0, pc_a[3], 3, 0);
        stall_i        = 1'b0;
        flush_i        = 4'b0000;
        strand_valid_i = 4'b0000;
        tick();
        chk("sf_idle.valid", 32'(valid_o), 32'h0);

        // VMT on strand 0: foreign flush ignored, own flush at lane 7 aborts.
        ins_a[0]       = vmt(0);
        strand_valid_i = 4'b1111;
        for (int l = 0; l < 7; l++) begin
            flush_i = (l == 3) ? 4'b0100 : 4'b0000;
            issue("vmt0", 4'b0000, vmt(0), 0, l);
        end
        flush_i = 4'b0001;
        #1;
        chk("abort.ready", 32'(strand_ready_o), 32'h0);
        tick();
        chk("abort.valid", 32'(valid_o), 32'h0);
        chk("abort.instr", instruction_o, 32'h0);
        issue("post_abort", 4'b0010, nvi(1), 1, 0);
        flush_i = 4'b0000;

        // Reset at lane 9 of a VMT on strand 2, overriding stall and flush.
        ins_a[0] = nvi(0);
        ins_a[2] = vmt(2);
        for (int l = 0; l < 9; l++) begin
            issue("vmt_r", 4'b0000, vmt(2), 2, l);
        end
        reset   = 1'b1;
        stall_i = 1'b1;
        flush_i = 4'b0100;
        #1;
        chk("mid_rst.ready", 32'(strand_ready_o), 32'h0);
        tick();
        chk_out("mid_rst", 1'b0, 32'h0, 32'h0, 0, 0);
        reset   = 1'b0;
        stall_i = 1'b0;
        flush_i = 4'b0000;
        ins_a[2] = nvi(2);
        issue("post_rst", 4'b0001, nvi(0), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_strand_select_stage.md
MULTI_STRAND_SELECT_STAGE -- requirements
Module: multi_strand_select_stage

Interface
REQ-001 Parameter NUM_STRANDS, default 4, number of hardware strands arbitrated (>=2).
REQ-002 Parameter NUM_LANES, default 16, lanes per vector memory transfer (power of 2, >=2).
REQ-003 Parameter LANE_W, default $clog2(NUM_LANES), width of the lane index.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 instruction_i  input  32*NUM_STRANDS  per-strand next instruction; strand s occupies bits [32*s+31:32*s].
REQ-007 pc_i  input  32*NUM_STRANDS  per-strand PC, same packing.
REQ-008 strand_valid_i  input  NUM_STRANDS  strand s presents a valid instruction.
REQ-009 flush_i  input  NUM_STRANDS  per-strand flush (rollback).
REQ-010 stall_i  input  1  downstream cannot accept; hold all outputs.
REQ-011 strand_ready_o  output  NUM_STRANDS  combinational one-hot pop; instruction of strand s fully consumed this cycle.
REQ-012 instruction_o  output  32  registered issued instruction; 0 (NOP) when invalid.
REQ-013 pc_o  output  32  registered PC of issued instruction.
REQ-014 strand_id_o  output  $clog2(NUM_STRANDS)  registered strand of issued instruction.
REQ-015 lane_select_o  output  LANE_W  registered lane index for vector memory transfers, else 0.
REQ-016 valid_o  output  1  registered; output register holds a live instruction.

Function
REQ-017 Vector memory transfer (VMT): instruction[31:30]==2'b10 and instruction[28:25]>=4'b0110.
REQ-018 Eligible strand: strand_valid_i[s]=1 and flush_i[s]=0.
REQ-019 FSM states IDLE and VMT; the stage SHALL leave state, pointers and outputs unchanged whenever stall_i=1, with strand_ready_o=0.
REQ-020 IDLE, no eligible strand: load valid_o=0, instruction_o=0, pc_o=0, lane_select_o=0; strand_ready_o=0.
REQ-021 IDLE: grant the first eligible strand at or after rr_ptr (wrapping modulo NUM_STRANDS); load its instruction/pc, strand_id_o=grant, lane_select_o=0, valid_o=1.
REQ-022 IDLE grant of a non-VMT: strand_ready_o[grant]=1 same cycle; rr_ptr<=grant+1 mod NUM_STRANDS.
REQ-023 IDLE grant of a VMT: strand_ready_o=0; enter VMT with locked strand=grant, lane counter=1 for next issue.
REQ-024 VMT: reissue the locked strand's instruction_i/pc_i with lane_select_o=counter, counter+1 per unstalled cycle; no other strand is granted.
REQ-025 VMT, issuing lane NUM_LANES-1: strand_ready_o[locked]=1, return to IDLE, rr_ptr<=locked+1 mod NUM_STRANDS.
REQ-026 Total VMT occupancy: exactly NUM_LANES unstalled issue cycles, lanes 0..NUM_LANES-1 in order, no gaps.
REQ-027 flush_i[locked] in VMT: abort, return to IDLE, load valid_o=0/instruction_o=0 that cycle, no strand_ready_o, rr_ptr unchanged; arbitration resumes next cycle.
REQ-028 flush_i[s] with valid_o=1 and strand_id_o==s SHALL clear valid_o and instruction_o next edge, even if stall_i=1.
REQ-029 Flush of a non-locked strand during VMT SHALL not disturb the transfer.
REQ-030 Lane counter SHALL wrap only via REQ-025; no lane value >= NUM_LANES issued.
REQ-031 Latency: one cycle from grant to registered outputs.

Reset
REQ-032 reset=1 at a clock edge: state IDLE, rr_ptr=0, lane counter=0, valid_o=0, instruction_o=0, pc_o=0, strand_id_o=0, lane_select_o=0.
REQ-033 strand_ready_o SHALL be 0 while reset=1; reset overrides stall_i and flush_i, including mid-VMT.

Structure
REQ-034 Shared package holds the VMT opcode-field constants (2'b10, 4'b0110), the NOP encoding and the IDLE/VMT state encoding.
REQ-035 One sub-module, rr_arbiter (NUM_STRANDS requests, pointer in, one-hot grant out), is used for REQ-021.

Verification (NUM_STRANDS=4, NUM_LANES=16)
REQ-036 All strands valid with non-VMT instructions, no stall -> strand_id_o sequence 0,1,2,3,0, strand_ready_o one-hot each cycle.
REQ-037 Strand 1 presents VMT, others valid -> 16 consecutive outputs strand 1, lanes 0..15, strand_ready_o[1] only on lane 15, then strand 2 granted.
REQ-038 VMT on strand 2, stall_i held 3 cycles at lane 5 -> outputs frozen at lane 5, resume at lane 6, total 16 issues.
REQ-039 VMT on strand 0, flush_i[0] at lane 7 -> valid_o=0 next cycle, no strand_ready_o[0], strand 1 granted following cycle.
REQ-040 reset asserted mid-VMT at lane 9 -> all outputs 0 next cycle, first post-reset grant strand 0.
REQ-041 No strand valid -> valid_o=0, instruction_o=0, strand_ready_o=0 for every cycle.
